fifo_sync_param: RTL

//  Single-clock, parametrised-width/depth FIFO on distributed RAM.

---
 rtl/fifo_sync_param.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO on distributed RAM with occupancy count,
// registered almost-full/almost-empty flags and optional sticky error flags (FIFO_SYNC_ERR_EN).
module fifo_sync_param #(
    parameter int WIDTH      = 16,
    parameter int N_log      = 6,
    parameter int AFULL_THR  = 60,
    parameter int AEMPTY_THR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_en,
    output logic             o_full,
    output logic             o_almost_full,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_rd_en,
    output logic             o_empty,
    output logic             o_almost_empty,
    output logic [N_log:0]   o_words,
    output logic             o_err_ovf,
    output logic             o_err_unf
);

    localparam int             DEPTH    = 1 << N_log;
    localparam logic [N_log:0] L_DEPTH  = (N_log+1)'(DEPTH);
    localparam logic [N_log:0] L_AFULL  = (N_log+1)'(AFULL_THR);
    localparam logic [N_log:0] L_AEMPTY = (N_log+1)'(AEMPTY_THR);

    // Handshake: a write is taken when i_wr_en & !o_full and a read when
    // i_rd_en & !o_empty, both judged on this cycle's registered flags.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [N_log-1:0] r_wr_ptr;
    logic [N_log-1:0] r_rd_ptr;
    logic [N_log:0]   r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [N_log:0]   w_count_nxt;

    assign w_wr_acc = i_wr_en & ~r_full;
    assign w_rd_acc = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + (N_log+1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - (N_log+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + N_log'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + N_log'(1);
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == L_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= L_AFULL);
            r_aempty <= (w_count_nxt <= L_AEMPTY);
        end
    end

    // Registered read pointer addresses the RAM asynchronously: head word is live.
    assign o_rd_data      = r_mem[r_rd_ptr];
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_words        = r_count;

`ifdef FIFO_SYNC_ERR_EN
    logic r_err_ovf;
    logic r_err_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (i_wr_en && r_full) begin
                r_err_ovf <= 1'b1;
            end
            if (i_rd_en && r_empty) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign o_err_ovf = r_err_ovf;
    assign o_err_unf = r_err_unf;
`else
    assign o_err_ovf = 1'b0;
    assign o_err_unf = 1'b0;
`endif

endmodule
